// File: rtl/cntr_pkg.sv
// Shared definitions for the interval timer and its embedded up-counter:
// control state encoding and the saturating increment used by exp_cnt.
package cntr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Increment v by one, holding at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/cntr.sv
// Plain up-counter with enable, synchronous clear and synchronous load.
// sclear and sload only take effect on an enabled cycle; sclear wins over sload.
module cntr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sclear,
  input  logic             sload,
  input  logic [WIDTH-1:0] sdata,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ena) begin
      if (sclear) begin
        q <= '0;
      end else if (sload) begin
        q <= sdata;
      end else begin
        q <= q + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/cntr_interval_timer.sv
// Interval timer: drives an embedded cntr to count P un-paused cycles per
// interval and emits a registered expire pulse at each interval end.
module cntr_interval_timer
  import cntr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 periodic,
  input  logic [WIDTH-1:0]     period,
  output logic                 busy,
  output logic                 expire,
  output logic                 err,
  output logic [WIDTH-1:0]     q,
  output logic [EXP_WIDTH-1:0] exp_cnt
);

  // Handshake-free control: start/stop are single-cycle strobes sampled on
  // each rising edge; pause is a level honoured only while running.

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     period_r;
  logic                 mode_r;

  logic                 run;
  logic                 start_ok;
  logic                 start_bad;
  logic                 at_end;
  logic                 wrap;
  logic                 clr;
  logic                 cnt_ena;
  logic [EXP_WIDTH-1:0] exp_cnt_nxt;

  // Priority stop > start > pause > wrap > increment is resolved here so
  // every downstream consumer sees already-qualified strobes.
  always_comb begin
    run       = (state == ST_RUN);
    start_ok  = start & ~stop & (period != '0);
    start_bad = start & ~stop & (period == '0);
    at_end    = (q == (period_r - WIDTH'(1)));
    wrap      = run & ~pause & at_end & ~stop & ~start_ok;
    clr       = stop | start_ok | wrap;
    cnt_ena   = (run & ~pause) | clr;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (start_ok) begin
      state_nxt = ST_RUN;
    end else if (wrap && !mode_r) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    exp_cnt_nxt = exp_cnt;
    if (stop) begin
      exp_cnt_nxt = exp_cnt;
    end else if (start_ok) begin
      exp_cnt_nxt = '0;
    end else if (wrap) begin
      exp_cnt_nxt = EXP_WIDTH'(sat_inc(32'(exp_cnt), EXP_WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_r <= '0;
      mode_r   <= 1'b0;
      expire   <= 1'b0;
      err      <= 1'b0;
      exp_cnt  <= '0;
    end else begin
      if (start_ok) begin
        period_r <= period;
        mode_r   <= periodic;
      end
      expire  <= wrap;
      err     <= start_bad;
      exp_cnt <= exp_cnt_nxt;
    end
  end

  assign busy = (state == ST_RUN);

  cntr #(
    .WIDTH(WIDTH)
  ) u_cntr (
    .clk   (clk),
    .rst   (rst),
    .ena   (cnt_ena),
    .sclear(clr),
    .sload (1'b0),
    .sdata ({WIDTH{1'b0}}),
    .q     (q)
  );

endmodule

// File: tb/tb_cntr_interval_timer.sv
// Bench for cntr_interval_timer: directed vector table, hand-written corner
// sequences, then random stimulus against an elapsed-cycle reference model.
module tb_cntr_interval_timer;

  localparam int WIDTH     = 8;
  localparam int EXP_WIDTH = 4;
  localparam int EXP_MAX   = (1 << EXP_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 stop;
  logic                 pause;
  logic                 periodic;
  logic [WIDTH-1:0]     period;
  logic                 busy;
  logic                 expire;
  logic                 err;
  logic [WIDTH-1:0]     q;
  logic [EXP_WIDTH-1:0] exp_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic                 start;
    logic                 stop;
    logic                 pause;
    logic                 periodic;
    logic [WIDTH-1:0]     period;
    logic                 busy;
    logic                 expire;
    logic                 err;
    logic [WIDTH-1:0]     q;
    logic [EXP_WIDTH-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: counts un-paused cycles since the last accepted start.
  bit m_run;
  bit m_mode;
  int m_p;
  int m_el;
  int m_exp;
  bit m_expire;
  bit m_err;

  cntr_interval_timer #(
    .WIDTH    (WIDTH),
    .EXP_WIDTH(EXP_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .periodic(periodic),
    .period  (period),
    .busy    (busy),
    .expire  (expire),
    .err     (err),
    .q       (q),
    .exp_cnt (exp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic b, input logic e, input logic er,
                            input logic [WIDTH-1:0] qv, input logic [EXP_WIDTH-1:0] ec);
    chk({tag, ".busy"},    32'(busy),    32'(b));
    chk({tag, ".expire"},  32'(expire),  32'(e));
    chk({tag, ".err"},     32'(err),     32'(er));
    chk({tag, ".q"},       32'(q),       32'(qv));
    chk({tag, ".exp_cnt"}, 32'(exp_cnt), 32'(ec));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic drive(input logic s, input logic st, input logic pa, input logic pe,
                       input logic [WIDTH-1:0] p);
    start    = s;
    stop     = st;
    pause    = pa;
    periodic = pe;
    period   = p;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic st, input logic pa, input logic pe,
                              input int p, input logic b, input logic e, input logic er,
                              input int qv, input int ec);
    vec_t v;
    v.start = s; v.stop = st; v.pause = pa; v.periodic = pe; v.period = WIDTH'(p);
    v.busy = b; v.expire = e; v.err = er; v.q = WIDTH'(qv); v.exp_cnt = EXP_WIDTH'(ec);
    return v;
  endfunction

  // Idle inputs carry a non-zero period and periodic=0 to show they are ignored mid-run.
  function automatic vec_t idle(input logic b, input logic e, input int qv, input int ec);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 7, b, e, 1'b0, qv, ec);
  endfunction

  task automatic model_reset();
    m_run = 0; m_mode = 0; m_p = 0; m_el = 0; m_exp = 0; m_expire = 0; m_err = 0;
  endtask

  task automatic model_step(input logic s, input logic st, input logic pa, input logic pe,
                            input logic [WIDTH-1:0] p);
    m_expire = 0;
    m_err    = 0;
    if (st) begin
      m_run = 0;
      m_el  = 0;
    end else if (s && p != 0) begin
      m_run  = 1;
      m_p    = int'(p);
      m_mode = pe;
      m_el   = 0;
      m_exp  = 0;
    end else begin
      if (s) m_err = 1;
      if (m_run && !pa) begin
        m_el++;
        if (m_el % m_p == 0) begin
          m_expire = 1;
          m_exp++;
          if (!m_mode) begin
            m_run = 0;
            m_el  = 0;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; pause = 0; periodic = 0; period = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, '0, '0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero period from IDLE.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0));
    // Periodic cadence P=5.
    vecs.push_back(mk(1, 0, 0, 1, 5, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 15; k++) vecs.push_back(idle(1, (k % 5) == 0, k % 5, k / 5));
    vecs.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 0, 7, 0, 0, 0, 0, 3));
    // One-shot P=4 with a 3-cycle pause after edge 2.
    vecs.push_back(mk(1, 0, 0, 0, 4, 1, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 1, 0));
    vecs.push_back(idle(1, 0, 2, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 1, 1, 7, 1, 0, 0, 2, 0));
    vecs.push_back(idle(1, 0, 3, 0));
    vecs.push_back(idle(0, 1, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    // Restart P=6 on a P=3 wrap edge, then stop+start together.
    vecs.push_back(mk(1, 0, 0, 1, 3, 1, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 1, 0));
    vecs.push_back(idle(1, 0, 2, 0));
    vecs.push_back(mk(1, 0, 0, 1, 6, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) vecs.push_back(idle(1, 0, k, 0));
    vecs.push_back(idle(1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 2, 0, 0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].periodic, vecs[i].period);
      check_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].expire, vecs[i].err,
                 vecs[i].q, vecs[i].exp_cnt);
    end

    // Saturation: P=1 periodic expires every cycle, exp_cnt sticks at all-ones.
    drive(1, 0, 0, 1, 8'd1);
    check_outs("sat.start", 1, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 0, 8'd9);
      check_outs($sformatf("sat%0d", k), 1, 1, 0, 0, EXP_WIDTH'((k > EXP_MAX) ? EXP_MAX : k));
    end

    // Asynchronous reset mid-interval at q=3, P=8.
    drive(1, 0, 0, 1, 8'd8);
    check_outs("ar.start", 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 0, 8'd2);
      check_outs($sformatf("ar.run%0d", k), 1, 0, 0, WIDTH'(k), 0);
    end
    #3 rst = 1'b1;
    #1;
    check_outs("ar.asserted", 0, 0, 0, 0, 0);
    #10 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, k[0], 1, 8'd3);
      check_outs($sformatf("ar.after%0d", k), 0, 0, 0, 0, 0);
    end

    // Random stimulus against the reference model.
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic s, st, pa, pe;
      logic [WIDTH-1:0] p;
      s  = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 24) == 0);
      pa = ($urandom_range(0, 3) == 0);
      pe = 1'($urandom_range(0, 1));
      p  = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom_range(1, 7));
      drive(s, st, pa, pe, p);
      model_step(s, st, pa, pe, p);
      check_outs($sformatf("rnd%0d", n), m_run, m_expire, m_err,
                 WIDTH'(m_run ? (m_el % m_p) : 0),
                 EXP_WIDTH'((m_exp > EXP_MAX) ? EXP_MAX : m_exp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
